// File: rtl/mem_stage_pkg.sv
// Shared widths, memory-op encodings and FSM state type for the MEM stage.
package mem_stage_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned AluSelBus  = 6;

  localparam logic [AluSelBus-1:0] MemopNone = 6'h00;
  localparam logic [AluSelBus-1:0] MemopLb   = 6'h01;
  localparam logic [AluSelBus-1:0] MemopLh   = 6'h02;
  localparam logic [AluSelBus-1:0] MemopLw   = 6'h03;
  localparam logic [AluSelBus-1:0] MemopLbu  = 6'h04;
  localparam logic [AluSelBus-1:0] MemopLhu  = 6'h05;
  localparam logic [AluSelBus-1:0] MemopSb   = 6'h06;
  localparam logic [AluSelBus-1:0] MemopSh   = 6'h07;
  localparam logic [AluSelBus-1:0] MemopSw   = 6'h08;

  localparam logic [RegAddrBus-1:0] NopRegAddr = '0;
  localparam logic [RegBus-1:0]     ZeroWord   = '0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mem_state_e;

  function automatic logic is_load(input logic [AluSelBus-1:0] op);
    return (op >= MemopLb) && (op <= MemopLhu);
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Decodes a memory op into mem_ctrl length/direction and extends returned load data.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [AluSelBus-1:0] memop_i,
  input  logic [RegBus-1:0]    rdata_i,
  output logic                 we_o,
  output logic [1:0]           len_o,
  output logic [RegBus-1:0]    ext_o
);

  always_comb begin
    we_o  = 1'b0;
    len_o = 2'd0;
    ext_o = rdata_i;
    case (memop_i)
      MemopLb: ext_o = {{24{rdata_i[7]}}, rdata_i[7:0]};
      MemopLbu: ext_o = {24'd0, rdata_i[7:0]};
      MemopLh: begin
        len_o = 2'd1;
        ext_o = {{16{rdata_i[15]}}, rdata_i[15:0]};
      end
      MemopLhu: begin
        len_o = 2'd1;
        ext_o = {16'd0, rdata_i[15:0]};
      end
      MemopLw: len_o = 2'd3;
      MemopSb: we_o = 1'b1;
      MemopSh: begin
        we_o  = 1'b1;
        len_o = 2'd1;
      end
      MemopSw: begin
        we_o  = 1'b1;
        len_o = 2'd3;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: ALU pass-through, plus a one-request FSM toward mem_ctrl for
// loads/stores that stalls the pipe until completion and holds the result in DONE.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] ex_wd,
  input  logic                  ex_wreg,
  input  logic [RegBus-1:0]     ex_wdata,
  input  logic [AluSelBus-1:0]  memop_type_i,
  input  logic [RegBus-1:0]     mem_addr_i,
  input  logic [RegBus-1:0]     mem_store_data_i,
  input  logic [5:0]            stall,
  output logic                  mc_req,
  output logic                  mc_we,
  output logic [RegBus-1:0]     mc_addr,
  output logic [1:0]            mc_len,
  output logic [RegBus-1:0]     mc_wdata,
  input  logic                  mc_done,
  input  logic [RegBus-1:0]     mc_rdata,
  output logic [RegAddrBus-1:0] mem_wd,
  output logic                  mem_wreg,
  output logic [RegBus-1:0]     mem_wdata,
  output logic [AluSelBus-1:0]  memop_type_o,
  output logic                  stallreq_mem
);

  mem_state_e           state_q, state_d;
  logic                 mc_req_q, mc_req_d;
  logic                 mc_we_q, mc_we_d;
  logic [1:0]           mc_len_q, mc_len_d;
  logic [RegBus-1:0]    mc_addr_q, mc_addr_d;
  logic [RegBus-1:0]    mc_wdata_q, mc_wdata_d;
  logic [RegBus-1:0]    result_q, result_d;
  logic [AluSelBus-1:0] op_q, op_d;

  logic [AluSelBus-1:0] ext_op;
  logic                 dec_we;
  logic [1:0]           dec_len;
  logic [RegBus-1:0]    ext_data;
  logic                 unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  // Decode the incoming op while idle; once issued, extend with the op that was latched.
  assign ext_op = (state_q == StIdle) ? memop_type_i : op_q;

  mem_load_ext u_load_ext (
    .memop_i (ext_op),
    .rdata_i (mc_rdata),
    .we_o    (dec_we),
    .len_o   (dec_len),
    .ext_o   (ext_data)
  );

  always_comb begin
    state_d    = state_q;
    mc_req_d   = mc_req_q;
    mc_we_d    = mc_we_q;
    mc_len_d   = mc_len_q;
    mc_addr_d  = mc_addr_q;
    mc_wdata_d = mc_wdata_q;
    result_d   = result_q;
    op_d       = op_q;
    case (state_q)
      StIdle: begin
        if (memop_type_i != MemopNone) begin
          state_d    = StBusy;
          mc_req_d   = 1'b1;
          mc_we_d    = dec_we;
          mc_len_d   = dec_len;
          mc_addr_d  = mem_addr_i;
          mc_wdata_d = mem_store_data_i;
          op_d       = memop_type_i;
        end
      end
      StBusy: begin
        if (mc_done) begin
          state_d  = StDone;
          mc_req_d = 1'b0;
          result_d = ext_data;
        end
      end
      StDone: begin
        // Leaving only when mem_wb captures keeps the same op from being re-issued.
        if (!stall[4]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mc_req_q   <= 1'b0;
      mc_we_q    <= 1'b0;
      mc_len_q   <= 2'd0;
      mc_addr_q  <= ZeroWord;
      mc_wdata_q <= ZeroWord;
      result_q   <= ZeroWord;
      op_q       <= MemopNone;
    end else begin
      state_q    <= state_d;
      mc_req_q   <= mc_req_d;
      mc_we_q    <= mc_we_d;
      mc_len_q   <= mc_len_d;
      mc_addr_q  <= mc_addr_d;
      mc_wdata_q <= mc_wdata_d;
      result_q   <= result_d;
      op_q       <= op_d;
    end
  end

  assign mc_req   = mc_req_q;
  assign mc_we    = mc_we_q;
  assign mc_len   = mc_len_q;
  assign mc_addr  = mc_addr_q;
  assign mc_wdata = mc_wdata_q;

  always_comb begin
    stallreq_mem = 1'b0;
    mem_wd       = ex_wd;
    mem_wreg     = ex_wreg;
    mem_wdata    = ex_wdata;
    memop_type_o = memop_type_i;
    if (rst) begin
      mem_wd       = NopRegAddr;
      mem_wreg     = 1'b0;
      mem_wdata    = ZeroWord;
      memop_type_o = MemopNone;
    end else begin
      case (state_q)
        StIdle: begin
          if (memop_type_i != MemopNone) begin
            stallreq_mem = 1'b1;
            mem_wreg     = 1'b0;
          end
        end
        StBusy: begin
          stallreq_mem = 1'b1;
          mem_wreg     = 1'b0;
        end
        StDone: begin
          if (is_load(op_q)) begin
            mem_wdata = result_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
